// File: rtl/rx_stream_cmd_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// rx_stream_cmd_scheduler_pkg
// Shared definitions for the RX stream-command scheduler:
//   - settings-bus register addresses
//   - command-word bit positions
//   - error codes reported on the error port
//   - scheduler FSM state encoding
//   - queued command entry layout and a helper that builds one
// ----------------------------------------------------------------------------
package rx_stream_cmd_scheduler_pkg;

   // Default queue depth (log2) and settings addresses
   localparam int unsigned DEF_CMD_FIFO_LOG2 = 4;
   localparam logic [7:0]  DEF_SR_RX_CMD     = 8'd152;
   localparam logic [7:0]  DEF_SR_RX_TIME_HI = 8'd153;
   localparam logic [7:0]  DEF_SR_RX_TIME_LO = 8'd154;

   // Command word layout
   localparam int unsigned CMD_SEND_IMM_BIT = 31;
   localparam int unsigned CMD_CHAIN_BIT    = 30;
   localparam int unsigned CMD_STOP_BIT     = 29;
   localparam int unsigned NUM_SAMPS_W      = 28;

   // Error codes
   localparam logic [3:0] ERR_NONE      = 4'd0;
   localparam logic [3:0] ERR_LATE      = 4'd1;
   localparam logic [3:0] ERR_UNDERFLOW = 4'd2;
   localparam logic [3:0] ERR_OVERFLOW  = 4'd3;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StWaitTime = 2'd1,
      StRunning  = 2'd2,
      StErrHold  = 2'd3
   } sched_state_e;

   // One queued command: the flags the FSM needs, the sample count and start time.
   // The stop flag is never queued, it acts immediately on the CMD write.
   typedef struct packed {
      logic                   send_imm;
      logic                   chain;
      logic [NUM_SAMPS_W-1:0] num_samps;
      logic [63:0]            cmd_time;
   } cmd_entry_t;

   localparam int unsigned CMD_ENTRY_W = $bits(cmd_entry_t);

   function automatic cmd_entry_t pack_cmd(input logic             send_imm,
                                           input logic             chain,
                                           input logic [NUM_SAMPS_W-1:0] num_samps,
                                           input logic [63:0]      cmd_time);
      cmd_entry_t e;
      e.send_imm  = send_imm;
      e.chain     = chain;
      e.num_samps = num_samps;
      e.cmd_time  = cmd_time;
      return e;
   endfunction

endpackage

// File: rtl/rx_stream_cmd_scheduler_cmd_fifo.sv
// ----------------------------------------------------------------------------
// rx_stream_cmd_scheduler_cmd_fifo
// Synchronous show-ahead FIFO holding queued stream commands.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_flush          : discard all entries (wins over push/pop in the same cycle)
//   i_push, i_wdata  : write an entry; ignored when full unless a pop happens too
//   i_pop            : consume the head entry; ignored when empty
//   o_rdata          : head entry (valid while !o_empty)
//   o_full, o_empty  : occupancy flags
// ----------------------------------------------------------------------------
module rx_stream_cmd_scheduler_cmd_fifo #(
   parameter int unsigned WIDTH      = 94,
   parameter int unsigned LOG2_DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [LOG2_DEPTH-1:0] r_wr_ptr;
   logic [LOG2_DEPTH-1:0] r_rd_ptr;
   logic [LOG2_DEPTH:0]   r_count;

   logic w_push_ok;
   logic w_pop_ok;

   assign o_full  = (r_count == (LOG2_DEPTH+1)'(DEPTH));
   assign o_empty = (r_count == '0);

   // A pop frees the slot the push needs, so both are honoured when full.
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   assign o_rdata = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + LOG2_DEPTH'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + LOG2_DEPTH'(1);
         unique case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (LOG2_DEPTH+1)'(1);
            2'b01:   r_count <= r_count - (LOG2_DEPTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge i_clk) begin
      if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/rx_stream_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// rx_stream_cmd_scheduler
// Per-channel RX stream-command sequencer. Commands arrive over the settings
// bus, are queued, and gate front-end strobes into a framed sample stream
// starting at the requested time. Errors are reported on a valid/ready port.
// Ports:
//   i_clk, i_reset_n         : clock, asynchronous active-low reset
//   i_set_stb/addr/data      : settings bus (CMD, TIME_HI, TIME_LO commits)
//   i_vita_time              : current time from the timekeeper
//   i_rx_stb                 : front-end sample strobe
//   o_samp_stb/sob/eob       : registered accepted-sample strobe and burst marks
//   o_rx_running             : scheduler is streaming
//   o_cmd_fifo_full          : command queue full
//   o_err_valid/code/time    : pending error, code, time of detection
//   i_err_ready              : error consumed
// ----------------------------------------------------------------------------
module rx_stream_cmd_scheduler
   import rx_stream_cmd_scheduler_pkg::*;
#(
   parameter int unsigned CMD_FIFO_LOG2 = DEF_CMD_FIFO_LOG2,
   parameter logic [7:0]  SR_RX_CMD     = DEF_SR_RX_CMD,
   parameter logic [7:0]  SR_RX_TIME_HI = DEF_SR_RX_TIME_HI,
   parameter logic [7:0]  SR_RX_TIME_LO = DEF_SR_RX_TIME_LO
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_set_stb,
   input  logic [7:0]  i_set_addr,
   input  logic [31:0] i_set_data,
   input  logic [63:0] i_vita_time,
   input  logic        i_rx_stb,
   output logic        o_samp_stb,
   output logic        o_samp_sob,
   output logic        o_samp_eob,
   output logic        o_rx_running,
   output logic        o_cmd_fifo_full,
   output logic        o_err_valid,
   output logic [3:0]  o_err_code,
   output logic [63:0] o_err_time,
   input  logic        i_err_ready
);

   // Settings decode and holding registers
   logic w_wr_cmd;
   logic w_wr_time_hi;
   logic w_push;
   logic w_stop_wr;
   logic w_unused_rsvd;

   logic                   r_hold_send_imm;
   logic                   r_hold_chain;
   logic [NUM_SAMPS_W-1:0] r_hold_num_samps;
   logic [31:0]            r_time_hi;

   assign w_wr_cmd      = i_set_stb && (i_set_addr == SR_RX_CMD);
   assign w_wr_time_hi  = i_set_stb && (i_set_addr == SR_RX_TIME_HI);
   assign w_push        = i_set_stb && (i_set_addr == SR_RX_TIME_LO);
   assign w_stop_wr     = w_wr_cmd && i_set_data[CMD_STOP_BIT];
   assign w_unused_rsvd = i_set_data[28];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_hold_send_imm  <= 1'b0;
         r_hold_chain     <= 1'b0;
         r_hold_num_samps <= '0;
         r_time_hi        <= '0;
      end else begin
         // A stop write only flushes; it does not disturb the staged command.
         if (w_wr_cmd && !i_set_data[CMD_STOP_BIT]) begin
            r_hold_send_imm  <= i_set_data[CMD_SEND_IMM_BIT];
            r_hold_chain     <= i_set_data[CMD_CHAIN_BIT];
            r_hold_num_samps <= i_set_data[NUM_SAMPS_W-1:0];
         end
         if (w_wr_time_hi) r_time_hi <= i_set_data;
      end
   end

   // Command queue
   cmd_entry_t w_push_entry;
   cmd_entry_t w_head;
   logic       w_fifo_full;
   logic       w_fifo_empty;
   logic       w_pop;
   logic       w_flush;
   logic       w_overflow;

   assign w_push_entry = pack_cmd(r_hold_send_imm, r_hold_chain, r_hold_num_samps,
                                  {r_time_hi, i_set_data});

   rx_stream_cmd_scheduler_cmd_fifo #(
      .WIDTH      (CMD_ENTRY_W),
      .LOG2_DEPTH (CMD_FIFO_LOG2)
   ) u_cmd_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_flush   (w_flush),
      .i_push    (w_push),
      .i_wdata   (w_push_entry),
      .i_pop     (w_pop),
      .o_rdata   (w_head),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   assign w_overflow = w_push && w_fifo_full && !w_pop;

   // Scheduler state
   sched_state_e           r_state;
   logic [NUM_SAMPS_W-1:0] r_remaining;
   logic                   r_cont;
   logic                   r_chain;
   logic [63:0]            r_cmd_time;
   logic                   r_first;
   logic                   r_stop_pend;
   logic                   r_ovf_pend;
   logic [3:0]             r_err_code;
   logic [63:0]            r_err_time;
   logic                   r_samp_stb;
   logic                   r_samp_sob;
   logic                   r_samp_eob;

   sched_state_e           w_state_nxt;
   logic                   w_load;
   logic                   w_first_nxt;
   logic [NUM_SAMPS_W-1:0] w_remaining_nxt;
   logic                   w_samp_stb_nxt;
   logic                   w_samp_sob_nxt;
   logic                   w_samp_eob_nxt;
   logic                   w_err_req;
   logic [3:0]             w_err_req_code;
   logic [3:0]             w_err_code_nxt;
   logic [63:0]            w_err_time_nxt;
   logic                   w_last;

   assign w_last = !r_cont && (r_remaining == NUM_SAMPS_W'(1));

   always_comb begin
      w_state_nxt     = r_state;
      w_pop           = 1'b0;
      w_load          = 1'b0;
      w_first_nxt     = r_first;
      w_remaining_nxt = r_remaining;
      w_samp_stb_nxt  = 1'b0;
      w_samp_sob_nxt  = 1'b0;
      w_samp_eob_nxt  = 1'b0;
      w_err_req       = 1'b0;
      w_err_req_code  = ERR_NONE;
      w_err_code_nxt  = r_err_code;
      w_err_time_nxt  = r_err_time;

      unique case (r_state)
         StIdle: begin
            if (r_ovf_pend) begin
               w_err_req      = 1'b1;
               w_err_req_code = ERR_OVERFLOW;
            end else if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_load      = 1'b1;
               w_first_nxt = 1'b1;
               w_state_nxt = w_head.send_imm ? StRunning : StWaitTime;
            end
         end

         StWaitTime: begin
            if (r_ovf_pend) begin
               w_err_req      = 1'b1;
               w_err_req_code = ERR_OVERFLOW;
            end else if (i_vita_time == r_cmd_time) begin
               w_state_nxt = StRunning;
            end else if (i_vita_time > r_cmd_time) begin
               w_err_req      = 1'b1;
               w_err_req_code = ERR_LATE;
            end
         end

         StRunning: begin
            // An overflow aborts the burst without an EOB, like a reset would.
            if (r_ovf_pend) begin
               w_err_req      = 1'b1;
               w_err_req_code = ERR_OVERFLOW;
            end else if (i_rx_stb) begin
               w_samp_stb_nxt = 1'b1;
               w_samp_sob_nxt = r_first;
               w_first_nxt    = 1'b0;
               if (r_stop_pend) begin
                  // Covers stop coinciding with the last sample: one EOB only.
                  w_samp_eob_nxt = 1'b1;
                  w_state_nxt    = StIdle;
               end else if (w_last) begin
                  if (!r_chain) begin
                     w_samp_eob_nxt = 1'b1;
                     w_state_nxt    = StIdle;
                  end else if (!w_fifo_empty) begin
                     // Seamless continuation: next entry's time/send_imm unused.
                     w_pop  = 1'b1;
                     w_load = 1'b1;
                  end else begin
                     w_samp_eob_nxt = 1'b1;
                     w_err_req      = 1'b1;
                     w_err_req_code = ERR_UNDERFLOW;
                  end
               end else if (!r_cont) begin
                  w_remaining_nxt = r_remaining - NUM_SAMPS_W'(1);
               end
            end
         end

         StErrHold: begin
            if (i_err_ready) begin
               w_state_nxt    = StIdle;
               w_err_code_nxt = ERR_NONE;
               w_err_time_nxt = '0;
            end
         end

         default: w_state_nxt = StIdle;
      endcase

      if (w_err_req) begin
         w_state_nxt    = StErrHold;
         w_err_code_nxt = w_err_req_code;
         w_err_time_nxt = i_vita_time;
      end
   end

   // Queue is emptied by a stop write and whenever an error is taken.
   assign w_flush = w_stop_wr || ((w_state_nxt == StErrHold) && (r_state != StErrHold));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= StIdle;
         r_remaining <= '0;
         r_cont      <= 1'b0;
         r_chain     <= 1'b0;
         r_cmd_time  <= '0;
         r_first     <= 1'b0;
         r_stop_pend <= 1'b0;
         r_ovf_pend  <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_err_time  <= '0;
         r_samp_stb  <= 1'b0;
         r_samp_sob  <= 1'b0;
         r_samp_eob  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_first    <= w_first_nxt;
         r_err_code <= w_err_code_nxt;
         r_err_time <= w_err_time_nxt;
         r_samp_stb <= w_samp_stb_nxt;
         r_samp_sob <= w_samp_sob_nxt;
         r_samp_eob <= w_samp_eob_nxt;

         if (w_load) begin
            r_remaining <= w_head.num_samps;
            r_cont      <= (w_head.num_samps == '0);
            r_chain     <= w_head.chain;
            r_cmd_time  <= w_head.cmd_time;
         end else begin
            r_remaining <= w_remaining_nxt;
         end

         // Stop only matters while streaming; anywhere else it is dropped.
         if (w_state_nxt != StRunning) begin
            r_stop_pend <= 1'b0;
         end else if (w_stop_wr && (r_state == StRunning)) begin
            r_stop_pend <= 1'b1;
         end

         if (w_overflow) begin
            r_ovf_pend <= 1'b1;
         end else if (w_err_req && (w_err_req_code == ERR_OVERFLOW)) begin
            r_ovf_pend <= 1'b0;
         end
      end
   end

   assign o_samp_stb      = r_samp_stb;
   assign o_samp_sob      = r_samp_sob;
   assign o_samp_eob      = r_samp_eob;
   assign o_rx_running    = (r_state == StRunning);
   assign o_cmd_fifo_full = w_fifo_full;
   assign o_err_valid     = (r_state == StErrHold);
   assign o_err_code      = r_err_code;
   assign o_err_time      = r_err_time;

endmodule
